// File: rtl/cfg_pkg.sv
// Shared defaults, encodings and FSM state type for the clock-chip configuration sequencer.
package cfg_pkg;

    localparam int         CLK_FREQ   = 125_000_000;
    localparam int         MEM_DEPTH  = 326;
    localparam int         MEM_WIDTH  = 24;
    localparam int         DATA_WIDTH = 8;
    localparam int         CYCLES     = MEM_WIDTH / DATA_WIDTH;
    localparam logic [6:0] SLAVE_ADDR = 7'h74;

    // 300 ms; dividing first keeps the product inside 32-bit integer range
    localparam int PAUSE_CYCLES = CLK_FREQ / 1000 * 300;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } r_w_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        SEND,
        WAIT_ACK,
        PAUSE,
        DONE,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/cfg_delay_cnt.sv
// One-shot down-counter: a load pulse arms it, expire is high on the cycle
// len-1 cycles after the load cycle (len must be at least 2).
module cfg_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= len - W'(1);
            run <= 1'b1;
        end else if (run) begin
            if (cnt == W'(1)) run <= 1'b0;
            cnt <= cnt - W'(1);
        end
    end

    assign expire = run && (cnt == W'(1));

endmodule

// File: rtl/cfg_seq_loader.sv
// ROM-driven I2C write sequencer for Si5340-class clock chips, with NACK retry.
// Define CFG_FAST_SIM_EN to shorten the post-preamble pause to 16 cycles.
module cfg_seq_loader #(
    parameter int         MEM_DEPTH    = cfg_pkg::MEM_DEPTH,
    parameter int         MEM_WIDTH    = cfg_pkg::MEM_WIDTH,
    parameter int         DATA_WIDTH   = cfg_pkg::DATA_WIDTH,
    parameter logic [6:0] SLAVE_ADDR   = cfg_pkg::SLAVE_ADDR,
    parameter int         PAUSE_IDX    = 2,
    parameter int         PAUSE_CYCLES = cfg_pkg::PAUSE_CYCLES,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
    input  logic [MEM_WIDTH-1:0]         rom_data_i,
    output logic [DATA_WIDTH-1:0]        tx_data_o,
    output logic                         tx_first_o,
    output logic                         tx_last_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    input  logic                         ack_valid_i,
    input  logic                         nack_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(MEM_DEPTH)-1:0] entry_o
);

    import cfg_pkg::*;

    localparam int AW              = $clog2(MEM_DEPTH);
    localparam int BYTES_PER_ENTRY = MEM_WIDTH / DATA_WIDTH;
    localparam int BW              = $clog2(BYTES_PER_ENTRY + 1);
    localparam int RW              = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef CFG_FAST_SIM_EN
    localparam int PAUSE_LEN = 16;
`else
    localparam int PAUSE_LEN = PAUSE_CYCLES;
`endif
    localparam int PW = $clog2(PAUSE_LEN + 1);

    seq_state_t           state;
    logic [AW-1:0]        entry;
    logic [BW-1:0]        byte_idx;
    logic [RW-1:0]        retry;
    logic [MEM_WIDTH-1:0] shreg;
    logic                 pause_load;
    logic                 pause_expire;
    logic                 last_entry;
    logic                 ack_ok;

    assign rom_addr_o = entry;
    assign entry_o    = entry;
    assign last_entry = (entry == AW'(MEM_DEPTH - 1));
    assign ack_ok     = ack_valid_i && !nack_i;

    cfg_delay_cnt #(
        .W(PW)
    ) u_pause (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (pause_load),
        .len    (PW'(PAUSE_LEN)),
        .expire (pause_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            entry      <= '0;
            byte_idx   <= '0;
            retry      <= '0;
            tx_data_o  <= '0;
            tx_first_o <= 1'b0;
            tx_last_o  <= 1'b0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            pause_load <= 1'b0;
        end else begin
            pause_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        done_o <= 1'b0;
                        err_o  <= 1'b0;
                        entry  <= '0;
                        retry  <= '0;
                        busy_o <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: state <= WAIT_ROM;
                WAIT_ROM: begin
                    byte_idx   <= '0;
                    tx_data_o  <= DATA_WIDTH'({SLAVE_ADDR, WRITE});
                    tx_first_o <= 1'b1;
                    tx_last_o  <= 1'b0;
                    tx_valid_o <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_valid_i && nack_i) begin
                        // the master has already issued STOP; restart the whole entry
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + RW'(1);
                            state <= FETCH;
                        end else begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= ERROR;
                        end
                    end else if (ack_ok && !tx_last_o) begin
                        byte_idx   <= byte_idx + BW'(1);
                        tx_data_o  <= shreg[MEM_WIDTH-1 -: DATA_WIDTH];
                        tx_first_o <= 1'b0;
                        tx_last_o  <= (byte_idx == BW'(BYTES_PER_ENTRY - 1));
                        tx_valid_o <= 1'b1;
                        state      <= SEND;
                    end else if (ack_ok && entry == AW'(PAUSE_IDX)) begin
                        pause_load <= 1'b1;
                        state      <= PAUSE;
                    end else if (ack_ok && last_entry) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else if (ack_ok) begin
                        entry <= entry + AW'(1);
                        retry <= '0;
                        state <= FETCH;
                    end
                end
                PAUSE: begin
                    if (pause_expire && last_entry) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else if (pause_expire) begin
                        entry <= entry + AW'(1);
                        retry <= '0;
                        state <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Entry bytes leave MSB-first; the register shifts once per acknowledged data byte.
    always_ff @(posedge clk_i) begin
        if (state == WAIT_ROM) begin
            shreg <= rom_data_i;
        end else if (state == WAIT_ACK && ack_ok && !tx_last_o) begin
            shreg <= shreg << DATA_WIDTH;
        end
    end

endmodule
